// File: rtl/spi_serializer.sv
// spi_serializer: transmit side of the SPI byte path.
// Bytes from the readback mux land in a one-entry holding register and are
// shifted out on poci MSB first, one bit per spi_clk. A byte already held when
// the current word's last bit completes is reloaded on that same edge, so
// consecutive words stream with no idle bit between them.
//
// Load handshake: a byte is taken on a rising edge of spi_clk where
// byte_valid && byte_ready. byte_ready is the inverse of the holding-register
// full flag. The producer keeps byte_in stable and byte_valid high until that
// edge. Loads are taken whatever the level of cs, so the next byte can be
// staged before the device is selected.
module spi_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              poci,
    output logic              byte_done,
    output logic              underrun,
    output logic              o_dbg_state
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_byte_done;
    logic              r_underrun;

    logic w_load;
    logic w_last_bit;
    logic w_take;

    // A load needs an empty holding register, and a take needs a full one.
    // The two can therefore never fall on the same edge.
    assign w_load     = byte_valid && !r_hold_full;
    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_take     = cs && r_hold_full &&
                        ((r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_last_bit));

    // Holding register. It keeps its contents through a cs abort and is lost only on rstn.
    always_ff @(posedge spi_clk) begin
        if (!rstn) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold      <= byte_in;
            r_hold_full <= 1'b1;
        end else if (w_take) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shift FSM. It steps through the word's bits, reloads back to back, and
    // flags an underrun when no next word is waiting.
    always_ff @(posedge spi_clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (!cs) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_shift   <= r_hold;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        r_byte_done <= 1'b1;
                        r_bit_cnt   <= '0;
                        if (r_hold_full) begin
                            r_shift <= r_hold;
                        end else begin
                            r_shift    <= '0;
                            r_state    <= ST_IDLE;
                            r_underrun <= 1'b1;
                        end
                    end else begin
                        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // poci is driven only from registers, so there is no input-to-pad path.
    assign byte_ready  = !r_hold_full;
    assign poci        = (r_state == ST_SHIFT) ? r_shift[DATA_W-1] : 1'b0;
    assign byte_done   = r_byte_done;
    assign underrun    = r_underrun;
    assign o_dbg_state = (r_state == ST_SHIFT);

endmodule

// File: doc/spi_serializer.md
Name: spi_serializer

Overview:
- Transmit-side counterpart of the SPI byte deserializer: serializes bytes from the register/control side onto poci, MSB first, one bit per spi_clk.
- One-entry holding register (double buffer) accepts the next byte during shifting, so back-to-back bytes stream with no gap.
- Sits between the SPI readback mux and the poci pad driver, in the spi_clk domain.

Parameters:
- DATA_W, 8, bits per serialized word. Bit counter width is clog2(DATA_W).

Ports:
- spi_clk  input  1  serialization clock; all state updates on posedge.
- rstn  input  1  chip-wide reset, synchronous, active-low.
- cs  input  1  chip select, active high; low acts as a synchronous local abort.
- byte_in  input  DATA_W  word to transmit.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  holding register empty; a load occurs when byte_valid && byte_ready at posedge.
- poci  output  1  serial data out.
- byte_done  output  1  one-cycle pulse when the last bit of a word has been driven.
- underrun  output  1  sticky flag: a word finished with cs high and no next word buffered.

Behaviour:
- State: hold_reg, hold_full, shift_reg, bit_cnt, fsm ∈ {IDLE, SHIFT}, byte_done_q, underrun_q.
- Reset (rstn=0 at posedge): hold_full=0, hold_reg=0, shift_reg=0, bit_cnt=0, fsm=IDLE, byte_done=0, underrun=0. rstn has priority over all other inputs.
- byte_ready = !hold_full (combinational), so it reads 1 out of reset. Loads are accepted regardless of cs, which allows preloading before selection.
- poci = shift_reg[DATA_W-1] when fsm=SHIFT, else 0. Registered source, no combinational path from inputs.
- cs=0 at posedge: fsm=IDLE, shift_reg=0, bit_cnt=0, underrun=0, byte_done=0. hold_reg and hold_full are preserved, and a load on that same edge is still accepted.
- IDLE with cs=1 and hold_full=1: shift_reg<=hold_reg, hold_full<=0, bit_cnt<=0, fsm<=SHIFT.
- SHIFT with cs=1, bit_cnt<DATA_W-1: shift_reg shifts left with 0 fill; bit_cnt++.
- SHIFT with cs=1, bit_cnt=DATA_W-1: byte_done<=1 for one cycle.
  - If hold_full=1: reload shift_reg from hold_reg, hold_full<=0, bit_cnt<=0, stay in SHIFT. No idle bit between words.
  - Else: fsm<=IDLE and underrun<=1.
- A byte loaded on the same edge the last bit completes is not used for that reload; it goes out via IDLE one cycle later.
- Latency: word accepted at edge N. If fsm=IDLE and cs=1, MSB appears on poci after edge N+1 and the LSB after edge N+DATA_W. byte_done is high during the cycle after edge N+DATA_W+1.
- Simultaneous load and transfer is impossible, because byte_ready=0 whenever hold_full=1.
- underrun stays set until rstn or cs=0, and it does not block further transmission.
- cs dropping mid-word discards the partial word with no byte_done. The next cs rise starts a fresh word from hold_reg if it is full.

Test Plan:
- Reset, then cs=1, load 0xA5 at edge 0 -> poci bits 1,0,1,0,0,1,0,1 after edges 1..8; byte_done one pulse; underrun=1 afterwards; byte_ready=1 from edge 1.
- cs=1, load 0x3C, then load 0xC3 while the first is shifting -> 16 contiguous bits 0011110011000011; byte_ready low between the second load and the reload; two byte_done pulses 8 cycles apart; underrun set only after the second word.
- cs=0, load 0x81 -> hold_full=1, poci=0; raise cs -> 1,0,0,0,0,0,0,1 starting one edge after cs rise.
- cs=1, shifting 0xFF, drop cs after 3 bits -> poci=0 next cycle; no byte_done; underrun=0; with 0x55 held, re-raise cs -> full 0x55 sent.
- rstn=0 for one edge mid-word with hold_full=1 -> all state cleared, poci=0, byte_ready=1, underrun=0, held byte lost.
- Underrun recovery: after underrun=1, load 0x0F with cs still high -> 0x0F transmitted normally, underrun stays 1 until cs=0.
